// File: rtl/act_gather.sv
// act_gather: reassembles 8-channel group beats (line -> group -> pixel) into 64-channel pixel vectors
// through a ping-pong line buffer. Define ACT_GATHER_RELU_EN to clamp negative output samples to zero.
module act_gather #(
    parameter int unsigned DW    = 24,
    parameter int unsigned MAX_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_config_valid,
    output logic              s_config_ready,
    input  logic [31:0]       s_config_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [8*DW-1:0]   s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [64*DW-1:0]  m_data,
    output logic              m_last,
    output logic [1:0]        status
);
    localparam int unsigned GW = 8 * DW;
    localparam int unsigned VW = 64 * DW;
    localparam int unsigned PW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    typedef enum logic [1:0] {CONFIG = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

    state_t        cs, ns;
    logic          err, err_set;
    logic          cfg_word, cfg_hs, cfg_bad;
    logic [11:0]   img_w0, img_h0;
    logic [23:0]   cfg_ch;
    logic [7:0]    cfg_wt;
    logic [3:0]    ngrp_w, ngrp;
    logic [2:0]    g_last;
    logic [PW-1:0] w_last;
    logic [19:0]   l_last;

    logic [PW-1:0] wpix, rpix;
    logic [2:0]    wgrp;
    logic [19:0]   wline, rline;
    logic          wsel, rsel;
    logic [1:0]    full, full_n;
    logic          wr, wr_line, wr_final;
    logic          rd_issue, rd_wrap, rd_last, p1_free, adv2;
    logic          p1_valid, p1_last;
    logic [VW-1:0] p1_data;

    logic [GW-1:0] mem [2][8][MAX_W];

    assign cfg_hs  = s_config_valid & s_config_ready;
    assign cfg_ch  = s_config_data[31:8];
    assign cfg_wt  = s_config_data[7:0];
    assign ngrp_w  = 4'((8'(cfg_ch[6:0]) + 8'd7) >> 3);
    assign cfg_bad = (img_w0 == 12'd0) || (img_w0 > 12'(MAX_W)) ||
                     (cfg_ch == 24'd0) || (cfg_ch > 24'd64);

    // Two-word configuration capture; derived limits are stored as last-index values
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_word <= 1'b0;
            img_w0   <= '0;
            img_h0   <= '0;
            w_last   <= '0;
            ngrp     <= 4'd1;
            g_last   <= '0;
            l_last   <= '0;
        end else if (cfg_hs) begin
            cfg_word <= ~cfg_word;
            if (!cfg_word) begin
                img_w0 <= s_config_data[11:0];
                img_h0 <= s_config_data[23:12];
            end else begin
                w_last <= PW'(img_w0 - 12'd1);
                ngrp   <= ngrp_w;
                g_last <= 3'(ngrp_w - 4'd1);
                l_last <= 20'(img_h0) * 20'(cfg_wt) - 20'd1;
            end
        end
    end

    assign s_ready  = (cs == RUN) & ~full[wsel];
    assign wr       = s_valid & s_ready;
    assign wr_line  = wr & (wpix == w_last) & (wgrp == g_last);
    assign wr_final = wr_line & (wline == l_last);

    assign adv2     = p1_valid & (~m_valid | m_ready);
    assign p1_free  = ~p1_valid | adv2;
    assign rd_issue = (cs != CONFIG) & full[rsel] & p1_free;
    assign rd_wrap  = rd_issue & (rpix == w_last);
    assign rd_last  = (rline == l_last) & (rpix == w_last);

    always_comb begin
        ns      = cs;
        err_set = 1'b0;
        case (cs)
            CONFIG: if (cfg_hs && cfg_word) begin
                if (cfg_bad) err_set = 1'b1;
                else         ns = RUN;
            end
            RUN:    if (wr_final) ns = FLUSH;
            FLUSH:  if (m_valid && m_ready && m_last) ns = CONFIG;
            default: ns = CONFIG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs             <= CONFIG;
            err            <= 1'b0;
            status         <= 2'd0;
            s_config_ready <= 1'b0;
        end else begin
            cs             <= ns;
            err            <= err | err_set;
            status         <= (err | err_set) ? 2'd3 : 2'(ns);
            s_config_ready <= (ns == CONFIG) & ~(err | err_set);
        end
    end

    // A write completing a line and a read freeing the other buffer never target the same flag
    always_comb begin
        full_n = full;
        if (wr_line) full_n[wsel] = 1'b1;
        if (rd_wrap) full_n[rsel] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || cs == CONFIG) begin
            wpix  <= '0;
            wgrp  <= '0;
            wline <= '0;
            wsel  <= 1'b0;
            rpix  <= '0;
            rline <= '0;
            rsel  <= 1'b0;
            full  <= '0;
        end else begin
            if (wr) begin
                wpix <= (wpix == w_last) ? '0 : wpix + PW'(1);
                if (wpix == w_last) begin
                    wgrp <= (wgrp == g_last) ? '0 : wgrp + 3'd1;
                    if (wgrp == g_last) begin
                        wsel  <= ~wsel;
                        wline <= wline + 20'd1;
                    end
                end
            end
            if (rd_issue) begin
                rpix <= rd_wrap ? '0 : rpix + PW'(1);
                if (rd_wrap) begin
                    rsel  <= ~rsel;
                    rline <= rline + 20'd1;
                end
            end
            full <= full_n;
        end
    end

    // Line buffer RAM with registered read of all eight banks
    always_ff @(posedge clk) begin
        if (wr) mem[wsel][wgrp][wpix] <= s_data;
        if (rd_issue)
            for (int g = 0; g < 8; g++)
                p1_data[VW-1-GW*g -: GW] <= mem[rsel][3'(g)][rpix];
    end

    function automatic logic [VW-1:0] shape(input logic [VW-1:0] d, input logic [3:0] n);
        logic [VW-1:0] r;
        r = d;
        for (int g = 0; g < 8; g++)
            if (4'(g) >= n) r[VW-1-GW*g -: GW] = '0;
`ifdef ACT_GATHER_RELU_EN
        for (int c = 0; c < 64; c++)
            if (r[DW*c+DW-1]) r[DW*c +: DW] = '0;
`endif
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p1_valid <= 1'b0;
            p1_last  <= 1'b0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_data   <= '0;
        end else begin
            p1_valid <= rd_issue | (p1_valid & ~adv2);
            if (rd_issue) p1_last <= rd_last;
            m_valid  <= adv2 | (m_valid & ~m_ready);
            if (adv2) begin
                m_data <= shape(p1_data, ngrp);
                m_last <= p1_last;
            end
        end
    end
endmodule

// File: tb/tb_act_gather.sv
// Testbench for act_gather: run table, backpressure, coincident wrap, ReLU and bad-config sequences.
`timescale 1ns/1ps
module tb_act_gather;
    localparam int unsigned DW    = 24;
    localparam int unsigned MAX_W = 64;
    localparam int unsigned GW    = 8 * DW;
    localparam int unsigned VW    = 64 * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_config_valid, s_config_ready;
    logic [31:0]   s_config_data;
    logic          s_valid, s_ready;
    logic [GW-1:0] s_data;
    logic          m_valid, m_ready;
    logic [VW-1:0] m_data;
    logic          m_last;
    logic [1:0]    status;

    act_gather #(.DW(DW), .MAX_W(MAX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_config_valid(s_config_valid), .s_config_ready(s_config_ready), .s_config_data(s_config_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .status(status)
    );

    always #5 clk = ~clk;

    typedef struct { logic [VW-1:0] d; logic last; } exp_t;
    typedef struct { int w; int h; int ch; int wt; int pat; int mode; int npix; } run_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            mon_bad;
    int            errors = 0, checks = 0;
    int            out_cnt, acc_cnt, max_stall, rdy_mode;
    bit            saw_last, drv_done;
    logic [GW-1:0] mdl [8][MAX_W];
    logic [VW-1:0] last_out, hold_d;
    logic          hold_pend, hold_l;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: stall stability and in-order comparison against the expected queue
    always @(negedge clk) begin
        if (!rst_n) hold_pend = 1'b0;
        else begin
            if (hold_pend) begin
                checks++;
                if (!m_valid || m_data !== hold_d || m_last !== hold_l) begin
                    errors++;
                    $display("FAIL hold: output changed while stalled, valid=%0b last=%0b", m_valid, m_last);
                end
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_pixel: unexpected output #%0d got none expected", out_cnt);
                end else begin
                    mon_e = exp_q.pop_front();
                    checks++;
                    if (m_data !== mon_e.d) begin
                        errors++;
                        mon_bad = -1;
                        for (int c = 0; c < 64; c++)
                            if (mon_bad < 0 && m_data[VW-1-DW*c -: DW] !== mon_e.d[VW-1-DW*c -: DW]) mon_bad = c;
                        if (mon_bad < 0) mon_bad = 0;
                        $display("FAIL pixel %0d ch %0d: got %06h expected %06h", out_cnt, mon_bad,
                                 m_data[VW-1-DW*mon_bad -: DW], mon_e.d[VW-1-DW*mon_bad -: DW]);
                    end
                    chk("m_last", 64'(m_last), 64'(mon_e.last));
                    if (mon_e.last) saw_last = 1'b1;
                end
                out_cnt++;
                last_out = m_data;
            end
            hold_pend = m_valid && !m_ready;
            hold_d    = m_data;
            hold_l    = m_last;
        end
    end

    task automatic send_cfg(input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] words [2];
        words[0] = w0;
        words[1] = w1;
        for (int k = 0; k < 2; k++) begin
            int t = 0;
            @(negedge clk);
            s_config_valid = 1'b1;
            s_config_data  = words[k];
            while (!s_config_ready && t < 100) begin @(negedge clk); t++; end
            if (t >= 100) begin
                checks++; errors++;
                $display("FAIL cfg_timeout: s_config_ready=0 after %0d cycles, expected 1", t);
            end
            @(posedge clk);
        end
        @(negedge clk);
        s_config_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [GW-1:0] d);
        int t = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && t < 2000) begin @(negedge clk); t++; end
        if (t >= 2000) begin
            checks++; errors++;
            $display("FAIL s_ready_timeout: s_ready=0 after %0d cycles, expected 1", t);
        end
        if (t > max_stall) max_stall = t;
        @(posedge clk);
        acc_cnt++;
    endtask

    task automatic push_line(input int w, input int ng, input bit last_line);
        exp_t          e;
        logic [DW-1:0] v;
        for (int p = 0; p < w; p++) begin
            e.d = '0;
            for (int c = 0; c < 64; c++) begin
                v = (c / 8 < ng) ? mdl[c/8][p][GW-1-DW*(c%8) -: DW] : '0;
`ifdef ACT_GATHER_RELU_EN
                if (v[DW-1]) v = '0;
`endif
                e.d[VW-1-DW*c -: DW] = v;
            end
            e.last = last_line && (p == w - 1);
            exp_q.push_back(e);
        end
    endtask

    // pat 0: sample = channel index; 1: random; 2: random with ch0=FFFFFF, ch1=5
    task automatic do_run(input int w, input int h, input int ch, input int wt, input int pat);
        int            ng, nl;
        logic [GW-1:0] d;
        ng = (ch + 7) / 8;
        nl = h * wt;
        send_cfg({8'd0, 12'(h), 12'(w)}, {24'(ch), 8'(wt)});
        for (int l = 0; l < nl; l++) begin
            for (int g = 0; g < ng; g++)
                for (int p = 0; p < w; p++) begin
                    for (int i = 0; i < 8; i++) begin
                        d[GW-1-DW*i -: DW] = (pat == 0) ? DW'(g * 8 + i) : DW'($urandom);
                        if (pat == 2 && g == 0 && i == 0) d[GW-1-DW*i -: DW] = 24'hFFFFFF;
                        if (pat == 2 && g == 0 && i == 1) d[GW-1-DW*i -: DW] = 24'h000005;
                    end
                    send_beat(d);
                    mdl[g][p] = d;
                end
            push_line(w, ng, l == nl - 1);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic start_run();
        exp_q.delete();
        saw_last  = 1'b0;
        out_cnt   = 0;
        acc_cnt   = 0;
        max_stall = 0;
    endtask

    task automatic wait_done(input int exp_n, input string nm);
        int t = 0;
        while (!(saw_last && exp_q.size() == 0) && t < 20000) begin @(negedge clk); t++; end
        chk({nm, "_done"}, 64'(t < 20000), 64'd1);
        @(negedge clk);
        chk({nm, "_status"}, 64'(status), 64'd0);
        chk({nm, "_count"}, 64'(out_cnt), 64'(exp_n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        run_t runs [5];
        int   bad_w [4];
        int   bad_c [4];
        int   t;
        runs[0] = '{4, 2, 64, 1, 0, 0, 8};
        runs[1] = '{4, 2, 20, 1, 1, 1, 8};
        runs[2] = '{64, 1, 9, 2, 1, 1, 128};
        runs[3] = '{1, 3, 1, 1, 1, 0, 3};
        runs[4] = '{5, 2, 57, 2, 1, 1, 20};
        bad_w   = '{65, 0, 4, 4};
        bad_c   = '{64, 64, 0, 65};

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0;
        s_config_valid = 1'b0; s_config_data = '0; rdy_mode = 0;
        start_run();
        repeat (2) @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data_nonzero", 64'(|m_data), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_status", 64'(status), 64'd0);
        rst_n = 1'b1;
        #1 chk("cfg_ready_after_rst", 64'(s_config_ready), 64'd0);
        @(negedge clk);
        chk("cfg_ready_idle", 64'(s_config_ready), 64'd1);

        for (int i = 0; i < 5; i++) begin
            start_run();
            rdy_mode = runs[i].mode;
            do_run(runs[i].w, runs[i].h, runs[i].ch, runs[i].wt, runs[i].pat);
            wait_done(runs[i].npix, $sformatf("run%0d", i));
        end

        // Downstream blocked for 200 cycles: exactly two lines buffered
        start_run();
        rdy_mode = 3;
        drv_done = 1'b0;
        fork
            begin
                do_run(8, 3, 8, 1, 1);
                drv_done = 1'b1;
            end
        join_none
        repeat (200) @(negedge clk);
        chk("bp_accepted", 64'(acc_cnt), 64'd16);
        chk("bp_s_ready", 64'(s_ready), 64'd0);
        chk("bp_m_valid", 64'(m_valid), 64'd1);
        rdy_mode = 0;
        wait_done(24, "bp");
        t = 0;
        while (!drv_done && t < 1000) begin @(negedge clk); t++; end
        chk("bp_driver_done", 64'(drv_done), 64'd1);

        // Continuous input with ngrp=1: read wrap and write line completion coincide
        start_run();
        rdy_mode = 0;
        do_run(4, 4, 8, 1, 1);
        wait_done(16, "wrap");
        chk("wrap_max_stall_le1", 64'(max_stall <= 1), 64'd1);

        start_run();
        rdy_mode = 0;
        do_run(1, 1, 2, 1, 2);
        wait_done(1, "relu");
`ifdef ACT_GATHER_RELU_EN
        chk("relu_neg", 64'(last_out[VW-1 -: DW]), 64'h0);
`else
        chk("relu_neg", 64'(last_out[VW-1 -: DW]), 64'hFFFFFF);
`endif
        chk("relu_pos", 64'(last_out[VW-1-DW -: DW]), 64'h5);

        for (int k = 0; k < 4; k++) begin
            send_cfg({8'd0, 12'd1, 12'(bad_w[k])}, {24'(bad_c[k]), 8'd1});
            s_valid = 1'b1;
            repeat (3) @(negedge clk);
            chk($sformatf("err%0d_status", k), 64'(status), 64'd3);
            chk($sformatf("err%0d_s_ready", k), 64'(s_ready), 64'd0);
            s_valid = 1'b0;
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            #1 chk($sformatf("err%0d_cleared", k), 64'(status), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
